// File: rtl/led_animator.sv
// LED strip animator: plays goal and win light patterns on a registered LED bus.
// One request is accepted from IDLE by fixed priority; the chosen animation runs for REPS
// repetitions, each made of K frames plus one dark gap frame, every frame held STEP_TICKS
// cycles. A one-cycle done pulse marks the return to IDLE.
// Optional build macro: ANIM_PREEMPT_EN lets a win request abort a running goal animation.
module led_animator #(
   parameter int LED_W      = 8,  // even, 4..32
   parameter int STEP_TICKS = 4,  // 1..255
   parameter int REPS       = 3   // 1..15
) (
   input  logic             BALL_CLOCK,
   input  logic             RESET_N,
   input  logic             goal_player_1,
   input  logic             goal_player_2,
   input  logic             win_player_1,
   input  logic             win_player_2,
   output logic [LED_W-1:0] led,
   output logic             busy,
   output logic             done,
   output logic [1:0]       anim_id
);

   localparam int HALF    = LED_W / 2;
   localparam int FRAME_W = $clog2(LED_W + 1);
   localparam int TICK_W  = $clog2(STEP_TICKS + 1);
   localparam int REP_W   = $clog2(REPS + 1);

   // Frame index of the dark gap; it follows the last lit frame.
   localparam logic [FRAME_W-1:0] K_GOAL    = FRAME_W'(LED_W);
   localparam logic [FRAME_W-1:0] K_WIN     = FRAME_W'(LED_W - 1);
   localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(STEP_TICKS - 1);
   localparam logic [REP_W-1:0]   REP_LAST  = REP_W'(REPS - 1);

   localparam logic [1:0] ID_GOAL_1 = 2'd0;
   localparam logic [1:0] ID_GOAL_2 = 2'd1;
   localparam logic [1:0] ID_WIN_1  = 2'd2;
   localparam logic [1:0] ID_WIN_2  = 2'd3;

   typedef enum logic [0:0] {IDLE, RUN} state_t;

   state_t               state_q;
   logic [FRAME_W-1:0]   frame_q;
   logic [TICK_W-1:0]    tick_q;
   logic [REP_W-1:0]     rep_q;

   logic                 req_valid;
   logic [1:0]           req_id;
   logic                 win_req;
   logic [1:0]           win_id;
   logic                 preempt;
   logic [FRAME_W-1:0]   k_last;
   logic [FRAME_W-1:0]   frame_next;

   // Lit pattern for a given animation and frame index (gap frames are handled by the caller).
   function automatic logic [LED_W-1:0] frame_pattern(input logic [1:0]         anim,
                                                      input logic [FRAME_W-1:0] idx);
      logic [LED_W-1:0] p;
      int               i;
      int               j;
      p = '0;
      i = int'(idx);
      j = i - HALF + 1;
      for (int b = 0; b < LED_W; b++) begin
         case (anim)
            ID_GOAL_1: p[b] = (b == LED_W - 1 - i);
            ID_GOAL_2: p[b] = (b == i);
            default: begin
               if (i < HALF) begin
                  // Converge: two dots walking in from both ends.
                  p[b] = (b == i) || (b == LED_W - 1 - i);
               end else if (anim == ID_WIN_1) begin
                  // Fill grows from the centre towards the top bit.
                  p[b] = (b >= HALF - 1) && (b <= HALF + j);
               end else begin
                  // Fill grows from the centre towards bit 0.
                  p[b] = (b >= HALF - 1 - j) && (b <= HALF);
               end
            end
         endcase
      end
      return p;
   endfunction

   // Fixed-priority request selection: wins over goals, player 1 over player 2.
   always_comb begin
      req_valid = 1'b1;
      req_id    = ID_GOAL_1;
      if (win_player_1) begin
         req_id = ID_WIN_1;
      end else if (win_player_2) begin
         req_id = ID_WIN_2;
      end else if (goal_player_1) begin
         req_id = ID_GOAL_1;
      end else if (goal_player_2) begin
         req_id = ID_GOAL_2;
      end else begin
         req_valid = 1'b0;
      end
   end

   // Win request decode used for preemption.
   always_comb begin
      win_req = win_player_1 || win_player_2;
      win_id  = win_player_1 ? ID_WIN_1 : ID_WIN_2;
   end

`ifdef ANIM_PREEMPT_EN
   // Only goal animations (anim_id[1] == 0) can be aborted, and only by a win.
   assign preempt = (state_q == RUN) && !anim_id[1] && win_req;
`else
   assign preempt = 1'b0;
`endif

   // Frame bookkeeping shared by the sequencer.
   always_comb begin
      k_last     = anim_id[1] ? K_WIN : K_GOAL;
      frame_next = frame_q + FRAME_W'(1);
   end

   // Animation sequencer with registered LED, busy, done and anim_id outputs.
   always_ff @(posedge BALL_CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         frame_q <= '0;
         tick_q  <= '0;
         rep_q   <= '0;
         led     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         anim_id <= ID_GOAL_1;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               frame_q <= '0;
               tick_q  <= '0;
               rep_q   <= '0;
               led     <= '0;
               busy    <= 1'b0;
               anim_id <= ID_GOAL_1;
               if (req_valid) begin
                  state_q <= RUN;
                  busy    <= 1'b1;
                  anim_id <= req_id;
                  led     <= frame_pattern(req_id, '0);
               end
            end

            RUN: begin
               if (preempt) begin
                  // Restart from scratch as the win animation; the goal never reports done.
                  frame_q <= '0;
                  tick_q  <= '0;
                  rep_q   <= '0;
                  anim_id <= win_id;
                  led     <= frame_pattern(win_id, '0);
               end else if (tick_q != TICK_LAST) begin
                  tick_q <= tick_q + TICK_W'(1);
               end else begin
                  tick_q <= '0;
                  if (frame_q == k_last) begin
                     // End of the gap: next repetition or finish.
                     frame_q <= '0;
                     if (rep_q == REP_LAST) begin
                        state_q <= IDLE;
                        rep_q   <= '0;
                        led     <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        anim_id <= ID_GOAL_1;
                     end else begin
                        rep_q <= rep_q + REP_W'(1);
                        led   <= frame_pattern(anim_id, '0);
                     end
                  end else begin
                     frame_q <= frame_next;
                     led     <= (frame_next == k_last) ? '0 : frame_pattern(anim_id, frame_next);
                  end
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
